// File: rtl/alu_result_serializer.sv
// Serializes ALU result/status words into framed bit streams (start, status, result, odd parity, stop).
// A one-word holding register lets the ALU post the next word while the current frame is shifting out.
module alu_result_serializer #(
  parameter int M            = 32,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         i_valid,
  input  logic [M-1:0] i_result,
  input  logic [3:0]   i_status,
  output logic         o_ready,
  output logic         o_sout,
  output logic         o_busy,
  output logic         o_frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(M + 4);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(M + 3);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic [M+3:0]  hold_data;
  logic          hold_par;
  logic          hold_full;
  logic [M+3:0]  shift_reg, shift_n;
  logic          par_reg, par_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [CW-1:0] bit_cnt, bit_n;
  logic          sout_n, done_n, busy_n;
  logic          load, accept, bit_end;

  // Accept and transfer are mutually exclusive: accept needs hold empty, transfer needs it full.
  assign accept  = i_valid && !hold_full;
  assign o_ready = !hold_full;
  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      hold_data <= '0;
      hold_par  <= 1'b0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_data <= {i_result, i_status};
      hold_par  <= ~^{i_status, i_result};
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      shift_reg    <= '0;
      par_reg      <= 1'b0;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      o_sout       <= 1'b1;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_n;
      shift_reg    <= shift_n;
      par_reg      <= par_n;
      baud_cnt     <= baud_n;
      bit_cnt      <= bit_n;
      o_sout       <= sout_n;
      o_busy       <= busy_n;
      o_frame_done <= done_n;
    end
  end

  // The line value is computed one cycle ahead so o_sout comes straight from a flop.
  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    par_n   = par_reg;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    sout_n  = o_sout;
    done_n  = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          state_n = START;
          load    = 1'b1;
          shift_n = hold_data;
          par_n   = hold_par;
          baud_n  = '0;
          sout_n  = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
          sout_n  = shift_reg[0];
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == BIT_LAST) begin
            state_n = PARITY;
            bit_n   = '0;
            sout_n  = par_reg;
          end else begin
            bit_n   = bit_cnt + 1'b1;
            shift_n = shift_reg >> 1;
            sout_n  = shift_reg[1];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          baud_n  = '0;
          sout_n  = 1'b1;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          done_n = 1'b1;
          // A waiting word starts immediately, with no idle bit between frames.
          if (hold_full) begin
            state_n = START;
            load    = 1'b1;
            shift_n = hold_data;
            par_n   = hold_par;
            sout_n  = 1'b0;
          end else begin
            state_n = IDLE;
            sout_n  = 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        sout_n  = 1'b1;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: two instances (M=8/CPB=2 and M=32/CPB=1), a line monitor
// that decodes frames against a scoreboard queue, plus table-driven and hand-written sequences.
module tb_alu_result_serializer;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic i_reset;
  int   cyc = 0;

  logic       v8, rdy8, so8, busy8, done8;
  logic [7:0] r8;
  logic [3:0] s8;
  logic        v32, rdy32, so32, busy32, done32;
  logic [31:0] r32;
  logic [3:0]  s32;

  int checks = 0;
  int fails  = 0;

  logic [38:0] q8[$];
  logic [38:0] q32[$];
  int          dt8[$];
  int          dt32[$];

  int          mm[2]  = '{8, 32};
  int          cpb[2] = '{2, 1};
  bit          active[2];
  bit          done_due[2];
  bit          bad[2];
  int          cnt[2];
  logic [38:0] bits[2];

  typedef struct {
    int          dut;
    logic [31:0] result;
    logic [3:0]  status;
    logic        parity;
  } vec_t;
  vec_t tbl[8];

  always #5 if (clk_en) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_result_serializer #(.M(8), .CLKS_PER_BIT(2)) dut8 (
    .clk(clk), .i_reset(i_reset), .i_valid(v8), .i_result(r8), .i_status(s8),
    .o_ready(rdy8), .o_sout(so8), .o_busy(busy8), .o_frame_done(done8)
  );

  alu_result_serializer #(.M(32), .CLKS_PER_BIT(1)) dut32 (
    .clk(clk), .i_reset(i_reset), .i_valid(v32), .i_result(r32), .i_status(s32),
    .o_ready(rdy32), .o_sout(so32), .o_busy(busy32), .o_frame_done(done32)
  );

  function automatic logic [38:0] make_frame(input int m, input logic [31:0] r,
                                             input logic [3:0] s, input logic p);
    logic [38:0] f;
    f = '0;
    f[4:1] = s;
    for (int i = 0; i < m; i++) f[5+i] = r[i];
    f[5+m] = p;
    f[6+m] = 1'b1;
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line decoder: frames start on the first low sample while idle; each bit is held cpb cycles.
  task automatic monStep(input int d, input logic sout, input logic done);
    int          bi;
    logic [38:0] exp;
    if (i_reset) begin
      active[d]   = 1'b0;
      done_due[d] = 1'b0;
      if (d == 0) q8.delete(); else q32.delete();
      return;
    end
    if (done_due[d]) begin
      checkOutput($sformatf("frame_done_pulse%0d", d), 64'(done), 64'd1);
      done_due[d] = 1'b0;
      if (d == 0) dt8.push_back(cyc); else dt32.push_back(cyc);
    end else if (done) begin
      checkOutput($sformatf("frame_done_spurious%0d", d), 64'(done), 64'd0);
    end
    if (!active[d] && sout == 1'b0) begin
      active[d] = 1'b1;
      cnt[d]    = 0;
      bits[d]   = '0;
      bad[d]    = 1'b0;
    end
    if (active[d]) begin
      bi = cnt[d] / cpb[d];
      if (cnt[d] % cpb[d] == 0) bits[d][bi] = sout;
      else if (sout !== bits[d][bi]) bad[d] = 1'b1;
      cnt[d]++;
      if (cnt[d] == (mm[d] + 7) * cpb[d]) begin
        active[d]   = 1'b0;
        done_due[d] = 1'b1;
        if ((d == 0 && q8.size() == 0) || (d == 1 && q32.size() == 0)) begin
          checkOutput($sformatf("frame_expected%0d", d), 64'd0, 64'd1);
        end else begin
          exp = (d == 0) ? q8.pop_front() : q32.pop_front();
          checkOutput($sformatf("frame_bits%0d", d), 64'(bits[d]), 64'(exp));
          checkOutput($sformatf("bit_hold_stable%0d", d), 64'(bad[d]), 64'd0);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    monStep(0, so8, done8);
    monStep(1, so32, done32);
  end

  // Leaves i_valid high after the accept edge; the caller drops it or sends the next word.
  task automatic applyStimulus(input int d, input logic [31:0] r, input logic [3:0] s,
                               input logic p, output int acc);
    int waited;
    waited = 0;
    acc = -1;
    @(negedge clk);
    if (d == 0) begin v8 = 1'b1; r8 = r[7:0]; s8 = s; end
    else begin v32 = 1'b1; r32 = r; s32 = s; end
    while (((d == 0) ? rdy8 : rdy32) == 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (((d == 0) ? rdy8 : rdy32) == 1'b0) begin
      checkOutput("accept_wait", 64'd0, 64'd1);
      v8 = 1'b0;
      v32 = 1'b0;
      return;
    end
    if (d == 0) q8.push_back(make_frame(8, r, s, p));
    else q32.push_back(make_frame(32, r, s, p));
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((q8.size() != 0 || q32.size() != 0 || active[0] || active[1] ||
            done_due[0] || done_due[1]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_idle", 64'(n < 500), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, a1, a2, a3, n0, lows, m, c;
    tbl[0] = '{0, 32'h0000_00FF, 4'hF, 1'b1};
    tbl[1] = '{0, 32'h0000_005A, 4'h6, 1'b1};
    tbl[2] = '{0, 32'h0000_0080, 4'h8, 1'b1};
    tbl[3] = '{0, 32'h0000_007F, 4'h3, 1'b0};
    tbl[4] = '{0, 32'h0000_0000, 4'h0, 1'b1};
    tbl[5] = '{1, 32'hFFFF_FFFF, 4'b1000, 1'b0};
    tbl[6] = '{1, 32'h0000_0001, 4'h0, 1'b0};
    tbl[7] = '{1, 32'hDEAD_BEEF, 4'h0, 1'b1};

    v8 = 1'b0; r8 = '0; s8 = '0;
    v32 = 1'b0; r32 = '0; s32 = '0;

    // T1: reset with the clock stopped
    i_reset = 1'b1;
    #5;
    checkOutput("rst_sout8", 64'(so8), 64'd1);
    checkOutput("rst_ready8", 64'(rdy8), 64'd1);
    checkOutput("rst_busy8", 64'(busy8), 64'd0);
    checkOutput("rst_done8", 64'(done8), 64'd0);
    checkOutput("rst_sout32", 64'(so32), 64'd1);
    checkOutput("rst_ready32", 64'(rdy32), 64'd1);
    checkOutput("rst_busy32", 64'(busy32), 64'd0);
    checkOutput("rst_done32", 64'(done32), 64'd0);
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    repeat (2) @(negedge clk);

    // T2: single frame, latency and done timing
    $display("[TB] T2 single frame A5/1");
    n0 = dt8.size();
    applyStimulus(0, 32'hA5, 4'b0001, 1'b0, acc);
    v8 = 1'b0;
    @(negedge clk);
    checkOutput("t2_idle_sout", 64'(so8), 64'd1);
    checkOutput("t2_held_ready", 64'(rdy8), 64'd0);
    checkOutput("t2_idle_busy", 64'(busy8), 64'd0);
    @(negedge clk);
    checkOutput("t2_start_sout", 64'(so8), 64'd0);
    checkOutput("t2_start_busy", 64'(busy8), 64'd1);
    checkOutput("t2_ready_back", 64'(rdy8), 64'd1);
    waitIdle();
    checkOutput("t2_done_count", 64'(dt8.size() - n0), 64'd1);
    if (dt8.size() > n0) checkOutput("t2_done_latency", 64'(dt8[dt8.size()-1] - (acc + 1)), 64'd30);
    checkOutput("t2_busy_after", 64'(busy8), 64'd0);

    // T3: back-to-back frames with i_valid held high
    $display("[TB] T3 back-to-back 01/02/03");
    n0 = dt8.size();
    applyStimulus(0, 32'h01, 4'h0, 1'b0, a1);
    applyStimulus(0, 32'h02, 4'h0, 1'b0, a2);
    applyStimulus(0, 32'h03, 4'h0, 1'b1, a3);
    v8 = 1'b0;
    checkOutput("t3_accept2_gap", 64'(a2 - a1), 64'd2);
    checkOutput("t3_accept3_gap", 64'(a3 - a1), 64'd32);
    waitIdle();
    checkOutput("t3_done_count", 64'(dt8.size() - n0), 64'd3);
    if (dt8.size() >= n0 + 3) begin
      checkOutput("t3_done_first", 64'(dt8[n0] - a1), 64'd31);
      checkOutput("t3_done_gap1", 64'(dt8[n0+1] - dt8[n0]), 64'd30);
      checkOutput("t3_done_gap2", 64'(dt8[n0+2] - dt8[n0+1]), 64'd30);
    end

    // Table-driven frames on both widths (includes all-zero word and all-ones M=32 word)
    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      m = (tbl[i].dut == 0) ? 8 : 32;
      c = (tbl[i].dut == 0) ? 2 : 1;
      n0 = (tbl[i].dut == 0) ? dt8.size() : dt32.size();
      applyStimulus(tbl[i].dut, tbl[i].result, tbl[i].status, tbl[i].parity, acc);
      v8 = 1'b0;
      v32 = 1'b0;
      waitIdle();
      if (tbl[i].dut == 0) begin
        checkOutput($sformatf("tbl%0d_done_count", i), 64'(dt8.size() - n0), 64'd1);
        if (dt8.size() > n0)
          checkOutput($sformatf("tbl%0d_frame_len", i), 64'(dt8[dt8.size()-1] - (acc + 1)), 64'((m + 7) * c));
      end else begin
        checkOutput($sformatf("tbl%0d_done_count", i), 64'(dt32.size() - n0), 64'd1);
        if (dt32.size() > n0)
          checkOutput($sformatf("tbl%0d_frame_len", i), 64'(dt32[dt32.size()-1] - (acc + 1)), 64'((m + 7) * c));
      end
    end

    // T5: reset mid-DATA with a second word held
    $display("[TB] T5 reset mid-frame");
    applyStimulus(0, 32'h5A, 4'h6, 1'b1, a1);
    applyStimulus(0, 32'h7F, 4'h3, 1'b0, a2);
    v8 = 1'b0;
    while (cyc < a1 + 12) @(negedge clk);
    checkOutput("t5_busy_before", 64'(busy8), 64'd1);
    checkOutput("t5_held_before", 64'(rdy8), 64'd0);
    i_reset = 1'b1;
    #1;
    checkOutput("t5_rst_sout", 64'(so8), 64'd1);
    checkOutput("t5_rst_ready", 64'(rdy8), 64'd1);
    checkOutput("t5_rst_busy", 64'(busy8), 64'd0);
    checkOutput("t5_rst_done", 64'(done8), 64'd0);
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    n0 = dt8.size();
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (so8 == 1'b0 || done8 == 1'b1) lows++;
    end
    checkOutput("t5_quiet_after_reset", 64'(lows), 64'd0);
    checkOutput("t5_no_done", 64'(dt8.size() - n0), 64'd0);
    applyStimulus(0, 32'h3C, 4'h2, 1'b0, acc);
    v8 = 1'b0;
    waitIdle();
    checkOutput("t5_recover_done", 64'(dt8.size() - n0), 64'd1);
    if (dt8.size() > n0) checkOutput("t5_recover_len", 64'(dt8[dt8.size()-1] - (acc + 1)), 64'd30);

    checkOutput("final_q8_empty", 64'(q8.size()), 64'd0);
    checkOutput("final_q32_empty", 64'(q32.size()), 64'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
